// File: rtl/kbd_cmd_arbiter.sv
// kbd_cmd_arbiter
//   Shares one PS/2 keyboard command interface between NUM_REQ requesters.
//   The arbiter grants round-robin and keeps one command in flight at a time.
//   Each command has a timeout, so a silent keyboard cannot hang the bus.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid/cmd/data per-requester request (byte i at [8i+7:8i])
//   req_accept         one-hot pulse: request captured
//   resp_valid         one-hot pulse: response for the owner
//   resp_data/status   result byte; 00 ok, 01 timeout, 10 rejected
//   cmd/cmd_data       command bytes to the keyboard controller
//   cmd_exec           one-cycle issue strobe to the controller
//   ctrl_ready         controller can accept a command
//   cmd_result         result byte from the controller
//   cmd_complete       result strobe from the controller
//   busy               high whenever the arbiter is not idle
//
// Build option
//   KBD_CMD_FILTER_EN  When defined, codes outside
//                      {ED,EE,F0,F3,F4,F5,FE,FF} are rejected without
//                      being issued (status 10).
module kbd_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_cmd,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_accept,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  output logic [1:0]           resp_status,
  output logic [7:0]           cmd,
  output logic [7:0]           cmd_data,
  output logic                 cmd_exec,
  input  logic                 ctrl_ready,
  input  logic [7:0]           cmd_result,
  input  logic                 cmd_complete,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        winner_q, winner_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   accept_d, resp_valid_d;
  logic [7:0]           resp_data_d, cmd_d, cmd_data_d;
  logic [1:0]           status_d;
  logic                 exec_d, busy_d;

  logic                 found;
  logic [IW-1:0]        pick;
  logic [7:0]           pick_cmd, pick_data;
  logic [NUM_REQ-1:0]   pick_oh, winner_oh;

`ifdef KBD_CMD_FILTER_EN
  function automatic logic cmd_legal(input logic [7:0] c);
    case (c)
      8'hED, 8'hEE, 8'hF0, 8'hF3, 8'hF4, 8'hF5, 8'hFE, 8'hFF: cmd_legal = 1'b1;
      default:                                               cmd_legal = 1'b0;
    endcase
  endfunction
`endif

  // Round-robin scan: start just after the last winner and wrap.
  // The first pending requester found wins.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_cmd  = req_cmd[{pick, 3'b000} +: 8];
  assign pick_data = req_data[{pick, 3'b000} +: 8];
  assign pick_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q;

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    accept_d     = '0;
    resp_valid_d = '0;
    resp_data_d  = resp_data;
    status_d     = resp_status;
    cmd_d        = cmd;
    cmd_data_d   = cmd_data;
    exec_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_ready && found) begin
          winner_d = pick;
          accept_d = pick_oh;
`ifdef KBD_CMD_FILTER_EN
          if (!cmd_legal(pick_cmd)) begin
            state_d      = RESP;
            resp_valid_d = pick_oh;
            resp_data_d  = '0;
            status_d     = 2'b10;
          end else begin
            cmd_d      = pick_cmd;
            cmd_data_d = pick_data;
            state_d    = ISSUE;
          end
`else
          cmd_d      = pick_cmd;
          cmd_data_d = pick_data;
          state_d    = ISSUE;
`endif
        end
      end
      ISSUE: begin
        exec_d  = 1'b1;
        cnt_d   = CW'(TIMEOUT_CYCLES);
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the cycle the counter expires still wins.
        if (cmd_complete) begin
          resp_valid_d = winner_oh;
          resp_data_d  = cmd_result;
          status_d     = 2'b00;
          state_d      = RESP;
        end else if (cnt_q <= CW'(1)) begin
          cnt_d        = '0;
          resp_valid_d = winner_oh;
          resp_data_d  = '0;
          status_d     = 2'b01;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_d  = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
      req_accept  <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      cmd         <= '0;
      cmd_data    <= '0;
      cmd_exec    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      req_accept  <= accept_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
      resp_status <= status_d;
      cmd         <= cmd_d;
      cmd_data    <= cmd_data_d;
      cmd_exec    <= exec_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_kbd_cmd_arbiter.sv
// Randomized bench for kbd_cmd_arbiter.
// A transaction-level reference model tracks grants, deadlines and responses.
module tb_kbd_cmd_arbiter;
  localparam int unsigned N = 3;
  localparam int unsigned T = 20;
  localparam int NCYC = 4000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_cmd, req_data;
  logic [N-1:0]   req_accept, resp_valid;
  logic [7:0]     resp_data, cmd, cmd_data, cmd_result;
  logic [1:0]     resp_status;
  logic           cmd_exec, ctrl_ready, cmd_complete, busy;

  always #5 clk = ~clk;

  kbd_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_data(req_data),
    .req_accept(req_accept), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_status(resp_status),
    .cmd(cmd), .cmd_data(cmd_data), .cmd_exec(cmd_exec),
    .ctrl_ready(ctrl_ready), .cmd_result(cmd_result),
    .cmd_complete(cmd_complete), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef KBD_CMD_FILTER_EN
  function automatic bit legal(input logic [7:0] c);
    return c inside {8'hED, 8'hEE, 8'hF0, 8'hF3, 8'hF4, 8'hF5, 8'hFE, 8'hFF};
  endfunction
`endif

  function automatic logic [7:0] rand_cmd();
    logic [7:0] codes [8] = '{8'hED, 8'hEE, 8'hF0, 8'hF3, 8'hF4, 8'hF5, 8'hFE, 8'hFF};
    if ($urandom_range(0, 3) != 0) return codes[$urandom_range(0, 7)];
    return 8'($urandom);
  endfunction

  // Reference model state
  bit         m_inflight;
  int         g, free_at, resp_k, last, win, comp_at, lat;
  logic [7:0] e_cmd, e_cmd_data, e_resp_data;
  logic [1:0] e_status;
  logic [N-1:0] e_acc, e_resp;
  bit         e_exec, e_busy;

  initial begin
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_data = '0;
    ctrl_ready = 1'b0; cmd_result = '0; cmd_complete = 1'b0;
    m_inflight = 0; last = N - 1; free_at = 0; resp_k = -10; comp_at = -1; g = -10;
    e_cmd = '0; e_cmd_data = '0; e_resp_data = '0; e_status = '0;

    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      #1;
      // Predict outputs from the inputs that were present at posedge k.
      e_acc = '0; e_resp = '0; e_exec = 0;
      if (rst) begin
        m_inflight = 0; last = N - 1; free_at = k + 1; resp_k = -10;
        e_cmd = '0; e_cmd_data = '0; e_resp_data = '0; e_status = '0;
      end else if (m_inflight) begin
        if (k == g + 1) e_exec = 1;
        else if (k > g + 1) begin
          if (cmd_complete) begin
            e_resp[win] = 1'b1; e_resp_data = cmd_result; e_status = 2'b00;
            m_inflight = 0; resp_k = k; free_at = k + 2; last = win;
          end else if (k == g + 1 + int'(T)) begin
            e_resp[win] = 1'b1; e_resp_data = 8'h00; e_status = 2'b01;
            m_inflight = 0; resp_k = k; free_at = k + 2; last = win;
          end
        end
      end else if (k >= free_at && ctrl_ready && req_valid != '0) begin
        win = -1;
        for (int j = 1; j <= int'(N); j++)
          if (win < 0 && req_valid[(last + j) % N]) win = (last + j) % N;
        e_acc[win] = 1'b1;
        g = k;
`ifdef KBD_CMD_FILTER_EN
        if (!legal(req_cmd[8*win +: 8])) begin
          e_resp[win] = 1'b1; e_resp_data = 8'h00; e_status = 2'b10;
          resp_k = k; free_at = k + 2; last = win;
        end else begin
          m_inflight = 1; e_cmd = req_cmd[8*win +: 8]; e_cmd_data = req_data[8*win +: 8];
        end
`else
        m_inflight = 1; e_cmd = req_cmd[8*win +: 8]; e_cmd_data = req_data[8*win +: 8];
`endif
      end
      e_busy = m_inflight || (resp_k == k);

      check_eq("req_accept", req_accept, e_acc);
      check_eq("resp_valid", resp_valid, e_resp);
      check_eq("cmd_exec", cmd_exec, e_exec);
      check_eq("busy", busy, e_busy);
      check_eq("cmd", cmd, e_cmd);
      check_eq("cmd_data", cmd_data, e_cmd_data);
      check_eq("resp_data", resp_data, e_resp_data);
      check_eq("resp_status", resp_status, e_status);

      // Stimulus for posedge k+1.
      rst = (k < 4) || ($urandom_range(0, 399) == 0);
      for (int i = 0; i < int'(N); i++) begin
        if (e_acc[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_cmd[8*i +: 8] = rand_cmd();
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
      end
      if (e_exec) begin
        case ($urandom_range(0, 3))
          0:       lat = int'(T);                              // tie with expiry
          1:       lat = int'(T) + 1 + int'($urandom_range(0, 2)); // timeout
          default: lat = 1 + int'($urandom_range(0, T - 2));
        endcase
        comp_at = k + lat;
      end
      cmd_complete = (k + 1 == comp_at) || (!m_inflight && $urandom_range(0, 19) == 0);
      cmd_result   = 8'($urandom);
      ctrl_ready   = ($urandom_range(0, 4) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
